pp_pipeline_accel_fifo_wr_arb: RTL and testbench

PP_PIPELINE_ACCEL_FIFO_WR_ARB -- requirements
Module: pp_pipeline_accel_fifo_wr_arb

---
 rtl/pp_pipeline_accel_arb_pkg.sv | 18 +
 rtl/pp_pipeline_accel_rr_pick.sv | 29 ++
 rtl/pp_pipeline_accel_fifo_wr_arb.sv | 123 ++++++++++++
 tb/tb_pp_pipeline_accel_fifo_wr_arb.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pp_pipeline_accel_arb_pkg.sv
// Shared types for the accelerator FIFO write arbiter: FSM encoding and counter widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pp_pipeline_accel_arb_pkg;

  // Arbiter FSM: IDLE picks the next holder, GRANT moves its words downstream.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Words moved in the current grant; BURST_LEN must fit in this width.
  localparam int BURST_CNT_W = 8;

  // Width of the optional downstream-stall statistics counter.
  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/pp_pipeline_accel_rr_pick.sv
// Round-robin picker: first set request bit searching upward from (last_i+1) mod N.
// Latency: purely combinational, zero cycles.
// Backpressure: none; vld_o low when no request bit is set.
module pp_pipeline_accel_rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  // Scan offsets from farthest to nearest so the nearest set bit after last_i wins;
  // offset N wraps onto last_i itself, giving the previous holder lowest priority.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    for (int k = N; k >= 1; k--) begin
      for (int i = 0; i < N; i++) begin
        if (req_i[i] && (((int'(last_i) + k) % N) == i)) begin
          idx_o = IW'(i);
          vld_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pp_pipeline_accel_fifo_wr_arb.sv
// Round-robin arbiter moving bursts of up to BURST_LEN words from NUM_REQ streams into one FIFO.
// Latency: one IDLE cycle to grant, then zero-latency combinational transfer per word.
// Backpressure: fifo_full_n low stalls the holder in GRANT; PP_PIPELINE_ACCEL_ARB_STATS_EN adds stall_cnt.
module pp_pipeline_accel_fifo_wr_arb
  import pp_pipeline_accel_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_empty_n,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dout,
  output logic [NUM_REQ-1:0]            req_read,
  input  logic                          fifo_full_n,
  output logic                          fifo_write,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
`ifdef PP_PIPELINE_ACCEL_ARB_STATS_EN
  ,
  output logic [STALL_CNT_W-1:0]        stall_cnt
`endif
);

  localparam int GW = $clog2(NUM_REQ);
  localparam logic [BURST_CNT_W-1:0] BURST_MAX = BURST_CNT_W'(BURST_LEN);

  arb_state_e             state_q;
  logic [GW-1:0]          grant_q;
  logic [GW-1:0]          last_q;
  logic [BURST_CNT_W-1:0] burst_cnt_q;
  logic [BURST_CNT_W-1:0] burst_cnt_d;

  logic [GW-1:0] pick_idx;
  logic          pick_vld;
  logic          holder_rdy;
  logic          xfer;

  pp_pipeline_accel_rr_pick #(
    .N  (NUM_REQ),
    .IW (GW)
  ) u_pick (
    .req_i  (req_empty_n),
    .last_i (last_q),
    .idx_o  (pick_idx),
    .vld_o  (pick_vld)
  );

  // Steer the holder's head word and pop strobe; a transfer never happens in a reset cycle.
  always_comb begin
    holder_rdy = 1'b0;
    fifo_din   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == GW'(i)) begin
        holder_rdy = req_empty_n[i];
        fifo_din   = req_dout[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    xfer        = (state_q == GRANT) && holder_rdy && fifo_full_n && !reset;
    fifo_write  = xfer;
    burst_cnt_d = burst_cnt_q + BURST_CNT_W'(1);
    req_read    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_read[i] = xfer && (grant_q == GW'(i));
    end
  end

  assign grant_id = grant_q;
  assign busy     = (state_q == GRANT) && !reset;

  // Grant FSM: pick in IDLE, count words in GRANT, release on full burst or empty holder.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      last_q      <= GW'(NUM_REQ - 1);
      burst_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            grant_q     <= pick_idx;
            burst_cnt_q <= '0;
            state_q     <= GRANT;
          end
        end
        GRANT: begin
          if (!holder_rdy) begin
            state_q <= IDLE;
            last_q  <= grant_q;
          end else if (fifo_full_n) begin
            burst_cnt_q <= burst_cnt_d;
            if (burst_cnt_d == BURST_MAX) begin
              state_q <= IDLE;
              last_q  <= grant_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef PP_PIPELINE_ACCEL_ARB_STATS_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  // Count cycles where the holder has data but the FIFO refuses it; saturate at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if ((state_q == GRANT) && holder_rdy && !fifo_full_n && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  // Statistics disabled: no stall counter or port.
`endif

endmodule

// File: tb/tb_pp_pipeline_accel_fifo_wr_arb.sv
// Self-checking bench for pp_pipeline_accel_fifo_wr_arb (NUM_REQ=4, DATA_WIDTH=4, BURST_LEN=4).
// Directed vector table plus multi-cycle sequences driven from a per-requester queue model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_pp_pipeline_accel_fifo_wr_arb;

  logic        clk;
  logic        reset;
  logic [3:0]  req_empty_n;
  logic [15:0] req_dout;
  logic [3:0]  req_read;
  logic        fifo_full_n;
  logic        fifo_write;
  logic [3:0]  fifo_din;
  logic [1:0]  grant_id;
  logic        busy;
`ifdef PP_PIPELINE_ACCEL_ARB_STATS_EN
  logic [15:0] stall_cnt;
`endif

  pp_pipeline_accel_fifo_wr_arb #(
    .NUM_REQ    (4),
    .DATA_WIDTH (4),
    .BURST_LEN  (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_empty_n (req_empty_n),
    .req_dout    (req_dout),
    .req_read    (req_read),
    .fifo_full_n (fifo_full_n),
    .fifo_write  (fifo_write),
    .fifo_din    (fifo_din),
    .grant_id    (grant_id),
    .busy        (busy)
`ifdef PP_PIPELINE_ACCEL_ARB_STATS_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Requester queue model.
  logic [3:0] mem [4][256];
  int hd [4];
  int tl [4];
  int wcount = 0;

  // Sequence tables: bit c (left to right) is cycle c.
  logic [0:15] v_ff, v_rst, v_wr, v_bsy;
  int          s_gid [16];

  typedef struct {
    logic [3:0] en;
    logic       ff;
    logic       wr;
    logic [3:0] rd;
    logic [1:0] gid;
    logic       bsy;
    logic [3:0] din;
  } vec_t;
  vec_t vt [26];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick(input logic [3:0] en, input logic [15:0] d, input logic ff, input logic rst);
    @(negedge clk);
    reset       = rst;
    req_empty_n = en;
    req_dout    = d;
    fifo_full_n = ff;
    #1;
  endtask

  task automatic clr();
    for (int r = 0; r < 4; r++) begin
      hd[r] = 0;
      tl[r] = 0;
    end
  endtask

  task automatic push(input int r, input logic [3:0] w);
    mem[r][tl[r] % 256] = w;
    tl[r]++;
  endtask

  // One cycle against the queue model with protocol and ordering checks.
  task automatic mcycle(input logic ff, input logic rst);
    logic [3:0]  en;
    logic [15:0] d;
    int          g;
    en = '0;
    d  = '0;
    g  = 0;
    for (int r = 0; r < 4; r++) begin
      if (tl[r] > hd[r]) begin
        en[r]       = 1'b1;
        d[r*4 +: 4] = mem[r][hd[r] % 256];
      end
    end
    tick(en, d, ff, rst);
    chk("wr_eq_anyrd", fifo_write, |req_read);
    chk("no_wr_full", fifo_write & ~fifo_full_n, 0);
    chk("no_rd_empty", req_read & ~req_empty_n, 0);
    if (rst) chk("rst_no_xfer", {fifo_write, req_read}, 0);
    if (fifo_write) begin
      chk("rd_onehot", $onehot(req_read), 1);
      for (int r = 0; r < 4; r++) if (req_read[r]) g = r;
      if (tl[g] > hd[g]) begin
        chk($sformatf("din_order_r%0d", g), fifo_din, mem[g][hd[g] % 256]);
        hd[g]++;
      end
      wcount++;
    end
  endtask

  task automatic do_reset();
    mcycle(1'b1, 1'b1);
    mcycle(1'b1, 1'b1);
  endtask

  task automatic run_seq(input string nm, input int c0, input int c1);
    for (int c = c0; c < c1; c++) begin
      mcycle(v_ff[c], v_rst[c]);
      chk($sformatf("%s_c%0d_wr", nm, c), fifo_write, v_wr[c]);
      chk($sformatf("%s_c%0d_busy", nm, c), busy, v_bsy[c]);
      if (s_gid[c] >= 0) chk($sformatf("%s_c%0d_gid", nm, c), grant_id, s_gid[c]);
    end
  endtask

  task automatic gid_none();
    for (int i = 0; i < 16; i++) s_gid[i] = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [1:0] gg;
    reset = 1'b1;
    req_empty_n = '0;
    req_dout = '0;
    fifo_full_n = 1'b1;

    // ---- Vector table: all four busy, head words A/B/C/D, then stall and empty-exit ----
    n = 0;
    for (int g = 0; g < 5; g++) begin
      vt[n] = '{en: 4'hF, ff: 1'b1, wr: 1'b0, rd: 4'b0, gid: (g == 0) ? 2'd0 : 2'(g - 1),
                bsy: 1'b0, din: 4'h0};
      n++;
      for (int b = 0; b < 4; b++) begin
        if (g < 4 || b == 0) begin
          gg = 2'(g % 4);
          vt[n] = '{en: 4'hF, ff: 1'b1, wr: 1'b1, rd: 4'b0001 << gg, gid: gg,
                    bsy: 1'b1, din: 4'hA + {2'b00, gg}};
          n++;
        end
      end
    end
    vt[22] = '{en: 4'hF, ff: 1'b0, wr: 1'b0, rd: 4'b0,    gid: 2'd0, bsy: 1'b1, din: 4'h0};
    vt[23] = '{en: 4'hE, ff: 1'b0, wr: 1'b0, rd: 4'b0,    gid: 2'd0, bsy: 1'b1, din: 4'h0};
    vt[24] = '{en: 4'hE, ff: 1'b1, wr: 1'b0, rd: 4'b0,    gid: 2'd0, bsy: 1'b0, din: 4'h0};
    vt[25] = '{en: 4'hE, ff: 1'b1, wr: 1'b1, rd: 4'b0010, gid: 2'd1, bsy: 1'b1, din: 4'hB};

    clr();
    tick(4'hF, 16'hDCBA, 1'b1, 1'b1);
    chk("rst_wr", fifo_write, 0);
    chk("rst_rd", req_read, 0);
    chk("rst_busy", busy, 0);
    tick(4'hF, 16'hDCBA, 1'b1, 1'b1);
    for (int i = 0; i < 26; i++) begin
      tick(vt[i].en, 16'hDCBA, vt[i].ff, 1'b0);
      chk($sformatf("vec%0d_wr", i), fifo_write, vt[i].wr);
      chk($sformatf("vec%0d_rd", i), req_read, vt[i].rd);
      chk($sformatf("vec%0d_gid", i), grant_id, vt[i].gid);
      chk($sformatf("vec%0d_busy", i), busy, vt[i].bsy);
      if (vt[i].wr) chk($sformatf("vec%0d_din", i), fifo_din, vt[i].din);
    end

    // ---- Lone requester 2 with 6 words: 4 writes, idle, re-grant, 2 writes, idle ----
    clr();
    for (int w = 1; w <= 6; w++) push(2, 4'(w));
    do_reset();
    v_ff = 16'hFFFF; v_rst = 16'h0000;
    v_wr  = 16'b0111_1011_0000_0000;
    v_bsy = 16'b0111_1011_1000_0000;
    gid_none();
    for (int c = 1; c < 10; c++) s_gid[c] = 2;
    run_seq("lone2", 0, 10);
    chk("lone2_drained", hd[2], 6);

    // ---- Requester 1, FIFO full for 3 cycles mid-burst ----
    clr();
    for (int w = 1; w <= 8; w++) push(1, 4'(w));
    do_reset();
    v_ff  = 16'b1110_0011_1111_1111; v_rst = 16'h0000;
    v_wr  = 16'b0110_0011_0000_0000;
    v_bsy = 16'b0111_1111_0000_0000;
    gid_none();
    for (int c = 1; c < 9; c++) s_gid[c] = 1;
    run_seq("stall1", 0, 9);
    chk("stall1_words", hd[1], 4);
`ifdef PP_PIPELINE_ACCEL_ARB_STATS_EN
    chk("stall1_stall_cnt", stall_cnt, 3);
`endif

    // ---- Requester 3 empties after 2 words; next grant goes to requester 0 ----
    clr();
    push(3, 4'h1); push(3, 4'h2);
    do_reset();
    v_ff = 16'hFFFF; v_rst = 16'h0000;
    v_wr  = 16'b0110_0100_0000_0000;
    v_bsy = 16'b0111_0100_0000_0000;
    gid_none();
    for (int c = 1; c < 5; c++) s_gid[c] = 3;
    s_gid[5] = 0;
    run_seq("empty3", 0, 4);
    push(0, 4'h5); push(0, 4'h6); push(1, 4'h7);
    run_seq("empty3", 4, 6);
    chk("empty3_rd", req_read, 4'b0001);

    // ---- Reset during the 3rd transfer of requester 2's burst ----
    clr();
    for (int w = 1; w <= 8; w++) begin
      push(1, 4'(w));
      push(2, 4'(w + 8));
    end
    do_reset();
    v_ff  = 16'hFFFF;
    v_rst = 16'b0000_0000_1000_0000;
    v_wr  = 16'b0111_1011_0010_0000;
    v_bsy = 16'b0111_1011_0010_0000;
    gid_none();
    for (int c = 1; c < 5; c++) s_gid[c] = 1;
    s_gid[6] = 2; s_gid[7] = 2; s_gid[9] = 0; s_gid[10] = 1;
    run_seq("rstmid", 0, 11);
    chk("rstmid_rd", req_read, 4'b0010);

    // ---- Random traffic with scoreboard ----
    clr();
    do_reset();
    begin
      logic [3:0] wseq [4];
      for (int r = 0; r < 4; r++) wseq[r] = 4'(r * 4);
      wcount = 0;
      for (int c = 0; c < 400; c++) begin
        for (int r = 0; r < 4; r++) begin
          if ($urandom_range(0, 2) == 0 && (tl[r] - hd[r]) < 100) begin
            push(r, wseq[r]);
            wseq[r] = wseq[r] + 4'd1;
          end
        end
        mcycle($urandom_range(0, 3) != 0, 1'b0);
      end
      chk("rand_progress", wcount > 100, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
